// File: rtl/serial_pkg.sv
// Shared line-level constants and FSM state encoding for the serial receiver/transmitter pair.
package serial_pkg;

  localparam logic MARK      = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BITCNT_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_HS1   = 3'd4,
    ST_HS2   = 3'd5
  } serial_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Loadable down-counter; expired_c_o is high while the count sits at zero.
module serial_bit_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          expired_c_o
);

  logic [CW-1:0] count_q, count_d;

  // Load wins over decrement so expiry and reload can share a cycle.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c_o = (count_q == '0);

endmodule

// File: rtl/serial_receiver.sv
// Async-frame serial receiver (start, 8 data LSB first, stop) with dav_n/rfd handshake.
// Define SERIAL_RX_FRAMING_ERR_EN to deliver bad-stop frames flagged on framing_err_o.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 1,
  parameter int unsigned CW          = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 rxd_i,
  input  logic                 rfd_i,
  output logic                 dav_n_o,
  output logic [DATA_BITS-1:0] byte_o
`ifdef SERIAL_RX_FRAMING_ERR_EN
  ,
  output logic                 framing_err_o
`endif
);

  localparam int unsigned HALF      = CLK_PER_BIT / 2;
  localparam int unsigned HALF_LOAD = (HALF > 0) ? HALF - 1 : 0;
  localparam int unsigned BIT_LOAD  = CLK_PER_BIT - 1;

  serial_state_e          state_q, state_d;
  logic                   rxd_q;
  logic [BITCNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   dav_n_q, dav_n_d;
  logic                   tmr_load;
  logic [CW-1:0]          tmr_val;
  logic                   tmr_expired;
`ifdef SERIAL_RX_FRAMING_ERR_EN
  logic                   ferr_q, ferr_d;
`endif

  serial_bit_timer #(.CW(CW)) u_timer (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .expired_c_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dav_n_d  = dav_n_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef SERIAL_RX_FRAMING_ERR_EN
    ferr_d   = ferr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        dav_n_d = 1'b1;
        // Falling edge only: a line parked at space never retriggers.
        if (rxd_q == MARK && rxd_i == START_BIT) begin
          tmr_load = 1'b1;
          bitcnt_d = '0;
          if (HALF == 0) begin
            state_d = ST_DATA;
            tmr_val = CW'(BIT_LOAD);
          end else begin
            state_d = ST_START;
            tmr_val = CW'(HALF_LOAD);
          end
        end
      end
      ST_START: begin
        if (tmr_expired) begin
          if (rxd_i == START_BIT) begin
            state_d  = ST_DATA;
            tmr_load = 1'b1;
            tmr_val  = CW'(BIT_LOAD);
            bitcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tmr_expired) begin
          shift_d  = {rxd_i, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
          tmr_load = 1'b1;
          tmr_val  = CW'(BIT_LOAD);
          if (bitcnt_q == BITCNT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tmr_expired) begin
          if (rxd_i == STOP_BIT) begin
            byte_d  = shift_q;
            dav_n_d = 1'b0;
            state_d = ST_HS1;
`ifdef SERIAL_RX_FRAMING_ERR_EN
            ferr_d  = 1'b0;
`endif
          end else begin
`ifdef SERIAL_RX_FRAMING_ERR_EN
            byte_d  = shift_q;
            dav_n_d = 1'b0;
            ferr_d  = 1'b1;
            state_d = ST_HS1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_HS1: begin
        if (!rfd_i) begin
          dav_n_d = 1'b1;
          state_d = ST_HS2;
        end
      end
      ST_HS2: begin
        if (rfd_i) begin
          state_d = ST_IDLE;
`ifdef SERIAL_RX_FRAMING_ERR_EN
          ferr_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        dav_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      rxd_q    <= MARK;
      bitcnt_q <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dav_n_q  <= 1'b1;
`ifdef SERIAL_RX_FRAMING_ERR_EN
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rxd_q    <= rxd_i;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dav_n_q  <= dav_n_d;
`ifdef SERIAL_RX_FRAMING_ERR_EN
      ferr_q   <= ferr_d;
`endif
    end
  end

  assign dav_n_o = dav_n_q;
  assign byte_o  = byte_q;
`ifdef SERIAL_RX_FRAMING_ERR_EN
  assign framing_err_o = ferr_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver at four clocks per bit; stimulus drives on negedge.
module tb_serial_receiver;

  localparam int unsigned CPB = 4;
  localparam int unsigned H   = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rfd;
  logic       dav_n;
  logic [7:0] rx_byte;
`ifdef SERIAL_RX_FRAMING_ERR_EN
  logic       ferr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Expected deliveries: {framing_err, byte}
  logic [8:0] exp_q[$];
  logic       dav_prev = 1'b1;

  serial_receiver #(.CLK_PER_BIT(CPB), .CW(8)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .rxd_i     (rxd),
    .rfd_i     (rfd),
    .dav_n_o   (dav_n),
    .byte_o    (rx_byte)
`ifdef SERIAL_RX_FRAMING_ERR_EN
    ,
    .framing_err_o (ferr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: every falling edge of dav_n must match the oldest expected delivery.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n === 1'b1 && dav_n === 1'b0 && dav_prev === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_dav: got byte 0x%0h, required no delivery", rx_byte);
      end else begin
        e = exp_q.pop_front();
        check("byte", 32'(rx_byte), 32'(e[7:0]));
`ifdef SERIAL_RX_FRAMING_ERR_EN
        check("framing_err", 32'(ferr), 32'(e[8]));
`endif
      end
    end
    dav_prev = dav_n;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_dav);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (H) @(negedge clk);
    check("pre_stop_dav", 32'(dav_n), 32'd1);
    @(negedge clk);
    check("stop_latency_dav", 32'(dav_n), expect_dav ? 32'd0 : 32'd1);
    repeat (CPB - H - 1) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic handshake(input int hold);
    int waited = 0;
    while (dav_n !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("dav_seen", 32'(dav_n), 32'd0);
    repeat (hold) @(negedge clk);
    check("dav_held", 32'(dav_n), 32'd0);
    rfd = 1'b0;
    @(negedge clk);
    check("dav_release", 32'(dav_n), 32'd1);
    repeat (3) @(negedge clk);
    check("dav_hs2", 32'(dav_n), 32'd1);
    rfd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic quiet(input string name, input int cycles);
    int lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dav_n !== 1'b1) lows++;
    end
    check(name, 32'(lows), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    rxd   = 1'b1;
    rfd   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dav", 32'(dav_n), 32'd1);
    check("reset_byte", 32'(rx_byte), 32'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame, immediate consumer
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b1);
    handshake(0);

    // Slow consumer: dav_n must stay low while rfd stays high
    exp_q.push_back({1'b0, 8'hC3});
    send_frame(8'hC3, 1'b1, 1'b1);
    handshake(20);

    // Two frames separated only by the handshake turnaround
    exp_q.push_back({1'b0, 8'h00});
    send_frame(8'h00, 1'b1, 1'b1);
    handshake(0);
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'hFF, 1'b1, 1'b1);
    handshake(0);

    // rfd already low on delivery: one-cycle dav_n pulse
    rfd = 1'b0;
    exp_q.push_back({1'b0, 8'h96});
    send_frame(8'h96, 1'b1, 1'b1);
    check("pulse_one_cycle", 32'(dav_n), 32'd1);
    quiet("pulse_hs2_quiet", 4);
    rfd = 1'b1;
    repeat (2) @(negedge clk);

    // Start glitch shorter than the half-bit recheck
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    quiet("glitch_no_dav", 12);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b1);
    handshake(0);

    // Bad stop bit
`ifdef SERIAL_RX_FRAMING_ERR_EN
    exp_q.push_back({1'b1, 8'h55});
    send_frame(8'h55, 1'b0, 1'b1);
    handshake(0);
`else
    send_frame(8'h55, 1'b0, 1'b0);
    quiet("bad_stop_no_dav", 12);
`endif

    // Reset in the middle of data bit 4
    d = 8'h81;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = d[4];
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_dav", 32'(dav_n), 32'd1);
    check("midreset_byte", 32'(rx_byte), 32'h00);
    rst_n = 1'b1;
    rxd   = 1'b1;
    quiet("midreset_quiet", 4);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 1'b1);
    handshake(0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
